// File: rtl/trng_pkg.sv
// Shared definitions for the entropy harvester: controller states and von Neumann pair codes.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  // {first, second} raw sample pairs that produce an output bit.
  localparam logic [1:0] PAIR_01 = 2'b01;
  localparam logic [1:0] PAIR_10 = 2'b10;

  function automatic logic pair_emits(input logic [1:0] pair);
    return (pair == PAIR_01) || (pair == PAIR_10);
  endfunction

endpackage

// File: rtl/trng_harvester_if.sv
// Random-word valid/ready channel; data is held stable while valid is high.
interface trng_harvester_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_debias.sv
// Von Neumann debiaser: pairs raw samples, emits on the second sample of a 01/10 pair.
// Zero latency on bit_valid; restart drops any half-formed pair.
module trng_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic sample,
  input  logic restart,
  output logic bit_valid,
  output logic bit_value
);

  logic       phase;
  logic       first;
  logic [1:0] pair;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      first <= 1'b0;
    end else if (restart) begin
      phase <= 1'b0;
    end else if (strobe) begin
      phase <= ~phase;
      if (!phase) first <= sample;
    end
  end

  always_comb begin
    pair      = {first, sample};
    bit_valid = strobe && phase && pair_emits(pair);
    bit_value = (pair == PAIR_10);
  end

endmodule

// File: rtl/trng_harvester.sv
// Entropy harvester: gates the oscillator, warms up, samples, health-tests, debiases and packs words.
// Word latency >= 2*WIDTH*SAMPLE_DIV cycles from COLLECT; word held in HOLD until ready, sampling continues.
module trng_harvester
  import trng_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SAMPLE_DIV = 16,
  parameter int WARMUP     = 1024,
  parameter int REP_LIMIT  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               metastable,
  output logic               osc_enable,
  output logic               fault,
  input  logic               clear_fault,
  trng_harvester_if.master   word
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int CNT_W  = $clog2(WIDTH + 1);

  state_t             state;
  state_t             next_state;
  logic               sync1;
  logic               sync2;
  logic [DIV_W-1:0]   div_cnt;
  logic [WARM_W-1:0]  warm_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic [REP_W-1:0]   rep_next;
  logic               prev_sample;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WIDTH-1:0]   word_q;
  logic               valid_q;

  logic               in_run;
  logic               strobe;
  logic               trip;
  logic               handshake;
  logic               warm_done;
  logic               word_done;
  logic               db_strobe;
  logic               db_restart;
  logic               db_valid;
  logic               db_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= metastable;
      sync2 <= sync1;
    end
  end

  always_comb begin
    in_run    = (state == ST_COLLECT) || (state == ST_HOLD);
    strobe    = in_run && (div_cnt == DIV_W'(SAMPLE_DIV - 1));
    warm_done = (warm_cnt == WARM_W'(WARMUP - 1));
    handshake = (state == ST_HOLD) && word.ready;

    if (rep_cnt == '0 || sync2 != prev_sample) rep_next = REP_W'(1);
    else                                       rep_next = rep_cnt + REP_W'(1);

    // The tripping sample must never reach the debiaser.
    trip       = strobe && (rep_next == REP_W'(REP_LIMIT));
    db_strobe  = strobe && !trip;
    db_restart = !in_run || handshake;
    word_done  = (state == ST_COLLECT) && db_valid && (bit_cnt == CNT_W'(WIDTH - 1));
  end

  trng_debias u_debias (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe    (db_strobe),
    .sample    (sync2),
    .restart   (db_restart),
    .bit_valid (db_valid),
    .bit_value (db_bit)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (enable) next_state = ST_WARMUP;
      end
      ST_WARMUP: begin
        if (!enable)        next_state = ST_IDLE;
        else if (warm_done) next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (!enable)        next_state = ST_IDLE;
        else if (trip)      next_state = ST_FAULT;
        else if (word_done) next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (!enable)        next_state = ST_IDLE;
        else if (trip)      next_state = ST_FAULT;
        else if (handshake) next_state = ST_COLLECT;
      end
      ST_FAULT: begin
        if (clear_fault) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      warm_cnt <= '0;
    end else begin
      if (!in_run)     div_cnt <= '0;
      else if (strobe) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);

      if (state == ST_WARMUP) warm_cnt <= warm_cnt + WARM_W'(1);
      else                    warm_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      prev_sample <= 1'b0;
    end else if (!in_run) begin
      rep_cnt     <= '0;
    end else if (strobe) begin
      rep_cnt     <= rep_next;
      prev_sample <= sync2;
    end
  end

  // Word register only shifts in COLLECT; HOLD keeps it as the offered data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      word_q  <= '0;
    end else begin
      if (!in_run || handshake)                   bit_cnt <= '0;
      else if (state == ST_COLLECT && db_valid)   bit_cnt <= bit_cnt + CNT_W'(1);

      if (next_state == ST_IDLE)                  word_q <= '0;
      else if (state == ST_COLLECT && db_valid)   word_q <= {word_q[WIDTH-2:0], db_bit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      osc_enable <= 1'b0;
      valid_q    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      osc_enable <= (next_state == ST_WARMUP) || (next_state == ST_COLLECT) ||
                    (next_state == ST_HOLD);
      valid_q    <= (next_state == ST_HOLD);
      fault      <= (next_state == ST_FAULT);
    end
  end

  assign word.data  = word_q;
  assign word.valid = valid_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Randomized bench for trng_harvester against a sample-level reference model.
module tb_trng_harvester;

  localparam int W  = 8;
  localparam int SD = 4;
  localparam int WU = 16;
  localparam int RL = 8;
  localparam int NS = 4096;

  localparam int P_IDLE  = 0;
  localparam int P_WARM  = 1;
  localparam int P_RUN   = 2;
  localparam int P_FAULT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic metastable = 1'b0;
  logic clear_fault = 1'b0;
  logic osc_enable;
  logic fault;

  trng_harvester_if #(.WIDTH(W)) bus ();

  trng_harvester #(
    .WIDTH(W), .SAMPLE_DIV(SD), .WARMUP(WU), .REP_LIMIT(RL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .metastable  (metastable),
    .osc_enable  (osc_enable),
    .fault       (fault),
    .clear_fault (clear_fault),
    .word        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: samples are indexed by strobe number from the COLLECT entry edge.
  int         cyc = 0;
  int         phase = P_IDLE;
  int         c_start = 0;
  bit         samp [NS];
  bit         m_osc = 1'b0;
  bit         m_fault = 1'b0;
  bit         m_valid = 1'b0;
  logic [W-1:0] m_word = '0;
  int         m_bits = 0;
  bit         m_have_first = 1'b0;
  bit         m_first = 1'b0;
  int         m_rep = 0;
  bit         m_prev = 1'b0;

  task automatic gen_samples(input int kind);
    logic [19:0] pre;
    int          run;
    bit          b;
    bit          prev;
    pre  = 20'b1001_1110_0010_0101_1010;
    run  = 0;
    prev = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (kind == 1)                b = 1'b1;
      else if (kind == 2 && i < 20) b = pre[19-i];
      else begin
        b = 1'($urandom_range(0, 1));
        if (i > 0 && b == prev && run >= RL - 1) b = ~prev;
      end
      run     = (i > 0 && b == prev) ? run + 1 : 1;
      prev    = b;
      samp[i] = b;
    end
  endtask

  task automatic model_edge();
    bit strobe;
    bit trip;
    bit hs;
    bit b;
    b = 1'b0;
    case (phase)
      P_IDLE: begin
        if (enable) begin
          phase   = P_WARM;
          c_start = cyc + WU;
          m_osc   = 1'b1;
        end
      end
      P_WARM: begin
        if (!enable) begin
          phase = P_IDLE;
          m_osc = 1'b0;
        end else if (cyc == c_start) begin
          phase        = P_RUN;
          m_have_first = 1'b0;
          m_bits       = 0;
          m_word       = '0;
          m_rep        = 0;
          m_valid      = 1'b0;
        end
      end
      P_RUN: begin
        if (!enable) begin
          phase   = P_IDLE;
          m_osc   = 1'b0;
          m_valid = 1'b0;
        end else begin
          hs     = m_valid && bus.ready;
          strobe = (cyc > c_start) && ((cyc - c_start) % SD == 0);
          trip   = 1'b0;
          if (strobe) begin
            b      = samp[((cyc - c_start) / SD - 1) % NS];
            m_rep  = (m_rep == 0 || b != m_prev) ? 1 : m_rep + 1;
            m_prev = b;
            trip   = (m_rep == RL);
          end
          if (trip) begin
            phase   = P_FAULT;
            m_fault = 1'b1;
            m_osc   = 1'b0;
            m_valid = 1'b0;
          end else if (hs) begin
            m_valid      = 1'b0;
            m_have_first = 1'b0;
            m_bits       = 0;
          end else if (strobe && !m_valid) begin
            if (!m_have_first) begin
              m_have_first = 1'b1;
              m_first      = b;
            end else begin
              m_have_first = 1'b0;
              if (m_first != b) begin
                m_word = {m_word[W-2:0], m_first};
                m_bits++;
                if (m_bits == W) m_valid = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        if (clear_fault) begin
          phase   = P_IDLE;
          m_fault = 1'b0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (phase == P_RUN) metastable = samp[((cyc - c_start) / SD) % NS];
    else                metastable = 1'($urandom_range(0, 1));
    check("osc_enable", osc_enable, m_osc);
    check("fault", fault, m_fault);
    check("valid", bus.valid, m_valid);
    if (m_valid) check("data", bus.data, m_word);
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n;
    n = 0;
    while (bus.valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check(tag, bus.valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ready = 1'b0;
    #12;
    rst_n = 1'b0;
    #1;
    check("reset_osc", osc_enable, 1'b0);
    check("reset_valid", bus.valid, 1'b0);
    check("reset_fault", fault, 1'b0);
    check("reset_data", bus.data, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Idle with enable low.
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_data", bus.data, '0);
    end

    // Warm-up and the directed pair sequence.
    gen_samples(2);
    bus.ready = 1'b1;
    enable    = 1'b1;
    tick();
    check("warm_osc", osc_enable, 1'b1);
    for (int i = 0; i < WU + SD - 1; i++) tick();
    wait_valid(2000, "directed_wait");
    check("directed_word", bus.data, 8'b1011_0011);
    tick();
    check("directed_one_pulse", bus.valid, 1'b0);

    // Backpressure hold, then a single transfer.
    bus.ready = 1'b0;
    wait_valid(3000, "bp_wait");
    for (int i = 0; i < 500; i++) tick();
    check("bp_still_valid", bus.valid, 1'b1);
    bus.ready = 1'b1;
    tick();
    check("bp_release", bus.valid, 1'b0);

    // Random ready pattern, with a stray clear_fault that must be ignored.
    for (int i = 0; i < 3000; i++) begin
      bus.ready   = 1'($urandom_range(0, 1));
      clear_fault = (i == 1234);
      tick();
    end
    clear_fault = 1'b0;

    // Abort while a word is pending.
    bus.ready = 1'b0;
    wait_valid(3000, "abort_wait");
    enable = 1'b0;
    tick();
    check("abort_valid", bus.valid, 1'b0);
    check("abort_osc", osc_enable, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    gen_samples(0);
    enable = 1'b1;
    bus.ready = 1'b1;
    wait_valid(3000, "reenable_wait");
    for (int i = 0; i < 20; i++) tick();

    // Health fault on a stuck source.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    gen_samples(1);
    enable = 1'b1;
    for (int i = 0; i < 200 && fault !== 1'b1; i++) tick();
    check("fault_set", fault, 1'b1);
    check("fault_valid", bus.valid, 1'b0);
    check("fault_osc", osc_enable, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("fault_sticky", fault, 1'b1);
    enable      = 1'b1;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("fault_cleared", fault, 1'b0);
    check("cleared_idle_osc", osc_enable, 1'b0);
    tick();
    check("rewarm_osc", osc_enable, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_harvester.md
# trng_harvester

Controller sequencing the free-running metastable oscillator entropy source into the rest of the design. It gates the oscillators, waits out a warm-up period and samples the asynchronous metastable bit at a fixed rate. Each raw sample goes through a repetition-count health test and von Neumann debiasing. The debiased bits are packed into WIDTH-bit words and offered on a valid/ready port. It sits between the metastable oscillator instance and any consumer of random words (key generation, nonce generation, seeding of LFSR-based PRNGs).

## Interface
Parameters:
- WIDTH, 32, output word width in bits (≥2)
- SAMPLE_DIV, 16, clock cycles between raw samples (≥2)
- WARMUP, 1024, cycles osc_enable is held before the first sample (≥1)
- REP_LIMIT, 32, consecutive identical raw samples that trip the fault (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous and active-low
- enable  in  1  level; harvester runs while high
- metastable  in  1  raw oscillator output, asynchronous to clk
- osc_enable  out  1  gate for the oscillator ring(s)
- data  out  WIDTH  random word, stable while valid
- valid  out  1  data available
- ready  in  1  consumer accepts data when valid && ready
- fault  out  1  health test failure, sticky
- clear_fault  in  1  single-cycle pulse, leaves FAULT

## Operation
- metastable is passed through a 2-FF synchronizer before any use. The synchronizer runs at all times.
- State machine: IDLE, WARMUP, COLLECT, HOLD, FAULT.
- IDLE → WARMUP when enable=1. WARMUP counts WARMUP cycles → COLLECT.
- COLLECT: on each sample strobe, the synchronized bit is taken as a raw sample.
  - Raw samples are paired (first, second).
  - 01 emits 0 and 10 emits 1. Pairs 00 and 11 are discarded.
  - Emitted bits shift into the word register at bit 0, existing bits move left.
  - When the WIDTH-th bit is emitted, the state goes to HOLD with valid=1.
- HOLD: sampling and the health test continue, but debiased bits are discarded. On valid && ready the state goes to COLLECT with the bit count at 0 and the pair phase reset.
- Health test (COLLECT and HOLD only):
  - rep_cnt is set to 1 on the first sample after WARMUP.
  - rep_cnt increments when a sample equals the previous sample, otherwise it reloads to 1.
  - When rep_cnt reaches REP_LIMIT, the state goes to FAULT. The tripping sample is never debiased.
- FAULT: fault=1, valid=0, osc_enable=0. Only a clear_fault pulse leaves FAULT, going to IDLE. clear_fault is ignored in other states.
- enable=0 in WARMUP, COLLECT or HOLD → IDLE in the next cycle. The partial word is discarded, valid drops without a handshake, and counters are cleared.
- enable=0 in FAULT has no effect, and fault stays set.
- osc_enable=1 in WARMUP, COLLECT and HOLD; 0 in IDLE and FAULT.

## Timing
- Reset values: osc_enable=0, data=0, valid=0, fault=0, state=IDLE, all counters 0.
- The enable→osc_enable latency is 1 cycle; osc_enable is registered.
- The first sample strobe comes SAMPLE_DIV cycles after entering COLLECT. Strobes then repeat every SAMPLE_DIV cycles. The divider keeps running through HOLD.
- Synchronizer latency is 2 cycles. A sample reflects metastable as it was 2 cycles before the strobe.
- valid rises in the cycle after the strobe that completes the word. data is registered and constant while valid=1.
- Handshake: the transfer occurs on any edge with valid && ready. valid is low in the next cycle unless the state is HOLD again, which needs at least 2·SAMPLE_DIV·WIDTH cycles. ready while valid=0 is ignored.
- A fault in the same cycle as a handshake: the word counts as transferred and the state goes to FAULT.
- The fault output is registered and rises 1 cycle after the tripping strobe.
- Minimum word latency from COLLECT: 2·WIDTH·SAMPLE_DIV cycles, with no upper bound.

## Structure
- Shared package trng_pkg holds:
  - the state enum (IDLE, WARMUP, COLLECT, HOLD, FAULT)
  - the debias pair encoding constants
- Sub-module trng_debias implements the von Neumann pairing. Inputs: sample strobe, sample bit, restart. Outputs: bit_valid, bit. The top level instantiates it once and owns the FSM, counters, health test and word register.

## Test plan
Parameters for all scenarios: WIDTH=8, SAMPLE_DIV=4, WARMUP=16, REP_LIMIT=8.
- Reset and idle: assert rst_n=0 mid-cycle, release, enable=0 for 100 cycles → all outputs 0 throughout.
- Warm-up: raise enable → osc_enable=1 one cycle later; no strobe before cycle 16+4 after osc_enable.
- Word assembly: drive metastable so the sampled pairs are 10,01,11,10,00,10,01,01,10,10 with ready=1 → valid pulses once with data=8'b10110011, and 11/00 pairs are dropped.
- Backpressure: ready=0 for 500 cycles after valid → data and valid stay stable; ready=1 → one transfer, valid=0 next cycle.
- Health fault: hold metastable=1 → fault=1 one cycle after the 8th consecutive sample, with valid=0 and osc_enable=0. A clear_fault pulse → IDLE; with enable still high → WARMUP again.
- Abort: drop enable while valid=1 and ready=0 → next cycle valid=0, osc_enable=0. Re-enable → the first word consists only of new samples.
